// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: round-robin share of one write path.
// Optional RF_WR_PROTECT_EN makes register 0 read-only.
module rf_write_arbiter #(
   parameter int NUM_REGS = 4,
   parameter int DATA_W   = 4,
   parameter int ADDR_W   = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_a,
   input  logic [ADDR_W-1:0]   addr_a,
   input  logic [DATA_W-1:0]   data_a,
   output logic                ack_a,
   input  logic                req_b,
   input  logic [ADDR_W-1:0]   addr_b,
   input  logic [DATA_W-1:0]   data_b,
   output logic                ack_b,
   output logic [NUM_REGS-1:0] wr_sel,
   output logic [DATA_W-1:0]   wr_data,
   output logic                addr_err,
   output logic                prio_b
);

   localparam logic [ADDR_W:0] LP_NREGS = (ADDR_W+1)'(NUM_REGS);

   logic                r_ack_a;
   logic                r_ack_b;
   logic [NUM_REGS-1:0] r_sel;
   logic [DATA_W-1:0]   r_data;
   logic                r_err;
   logic                r_prio_b;

   logic                w_eff_a;
   logic                w_eff_b;
   logic                w_gnt_a;
   logic                w_gnt_b;
   logic                w_cont;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]   w_data;
   logic [NUM_REGS-1:0] w_sel;
   logic                w_err;

   // Grant selection, address decode and range check for the next issue.
   always_comb begin
      w_eff_a = req_a & ~r_ack_a;
      w_eff_b = req_b & ~r_ack_b;
      w_cont  = w_eff_a & w_eff_b;
      w_gnt_a = w_eff_a & (~w_eff_b | ~r_prio_b);
      w_gnt_b = w_eff_b & ~w_gnt_a;
      w_addr  = w_gnt_b ? addr_b : addr_a;
      w_data  = w_gnt_b ? data_b : data_a;
      w_err   = ({1'b0, w_addr} >= LP_NREGS);
      w_sel   = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_addr == ADDR_W'(i)) begin
            w_sel[i] = 1'b1;
         end
      end
`ifdef RF_WR_PROTECT_EN
      if (w_addr == '0) begin
         w_sel = '0;
      end
`endif
      if (!(w_gnt_a | w_gnt_b)) begin
         w_sel = '0;
         w_err = 1'b0;
      end
   end

   // Register the issue: acks, load enables, data and pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ack_a  <= 1'b0;
         r_ack_b  <= 1'b0;
         r_sel    <= '0;
         r_data   <= '0;
         r_err    <= 1'b0;
         r_prio_b <= 1'b0;
      end else begin
         r_ack_a <= w_gnt_a;
         r_ack_b <= w_gnt_b;
         r_sel   <= w_sel;
         r_err   <= w_err;
         if (w_gnt_a | w_gnt_b) begin
            r_data <= w_data;
         end
         if (w_cont) begin
            r_prio_b <= w_gnt_a;
         end
      end
   end

   assign ack_a    = r_ack_a;
   assign ack_b    = r_ack_b;
   assign wr_sel   = r_sel;
   assign wr_data  = r_data;
   assign addr_err = r_err;
   assign prio_b   = r_prio_b;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed scoreboard bench for rf_write_arbiter.
// Second instance uses NUM_REGS=3 to reach the out-of-range path.
module tb_rf_write_arbiter;

   typedef struct packed {
      logic       ea;
      logic       eb;
      logic [3:0] es;
      logic [3:0] ed;
      logic       ee;
      logic       ep;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_a, req_b;
   logic [1:0] addr_a, addr_b;
   logic [3:0] data_a, data_b;
   logic       ack_a, ack_b, addr_err, prio_b;
   logic [3:0] wr_sel, wr_data;

   logic       req_a2, req_b2;
   logic [1:0] addr_a2, addr_b2;
   logic [3:0] data_a2, data_b2;
   logic       ack_a2, ack_b2, addr_err2, prio_b2;
   logic [2:0] wr_sel2;
   logic [3:0] wr_data2;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   rf_write_arbiter #(.NUM_REGS(4), .DATA_W(4), .ADDR_W(2)) u_dut (
      .clk(clk), .reset(reset),
      .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a),
      .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b),
      .wr_sel(wr_sel), .wr_data(wr_data),
      .addr_err(addr_err), .prio_b(prio_b)
   );

   rf_write_arbiter #(.NUM_REGS(3), .DATA_W(4), .ADDR_W(2)) u_dut3 (
      .clk(clk), .reset(reset),
      .req_a(req_a2), .addr_a(addr_a2), .data_a(data_a2), .ack_a(ack_a2),
      .req_b(req_b2), .addr_b(addr_b2), .data_b(data_b2), .ack_b(ack_b2),
      .wr_sel(wr_sel2), .wr_data(wr_data2),
      .addr_err(addr_err2), .prio_b(prio_b2)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag,
                       input logic rs,
                       input logic ra, input logic [1:0] aa,
                       input logic [3:0] da,
                       input logic rb, input logic [1:0] ab,
                       input logic [3:0] db,
                       input logic ea, input logic eb,
                       input logic [3:0] es, input logic [3:0] ed,
                       input logic ee, input logic ep);
      exp_t e;
      reset  = rs;
      req_a  = ra; addr_a = aa; data_a = da;
      req_b  = rb; addr_b = ab; data_b = db;
      q.push_back('{ea, eb, es, ed, ee, ep});
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk({tag, ".ack_a"}, 32'(ack_a), 32'(e.ea));
      chk({tag, ".ack_b"}, 32'(ack_b), 32'(e.eb));
      chk({tag, ".wr_sel"}, 32'(wr_sel), 32'(e.es));
      chk({tag, ".wr_data"}, 32'(wr_data), 32'(e.ed));
      chk({tag, ".addr_err"}, 32'(addr_err), 32'(e.ee));
      chk({tag, ".prio_b"}, 32'(prio_b), 32'(e.ep));
   endtask

   initial begin
      reset = 1'b1;
      req_a = 0; addr_a = 0; data_a = 0;
      req_b = 0; addr_b = 0; data_b = 0;
      req_a2 = 0; addr_a2 = 0; data_a2 = 0;
      req_b2 = 0; addr_b2 = 0; data_b2 = 0;
      @(posedge clk);
      #1;

      // reset held with a pending request
      step("rst0", 1, 1, 2, 4'h3, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
      step("rst1", 1, 1, 2, 4'h3, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
      step("rst2", 1, 1, 2, 4'h3, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
      step("rel0", 0, 1, 2, 4'h3, 0, 0, 0, 1, 0, 4'b0100, 4'h3, 0, 0);
      step("rel1", 0, 1, 2, 4'h3, 0, 0, 0, 0, 0, 4'b0000, 4'h3, 0, 0);
      step("idle0", 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'b0000, 4'h3, 0, 0);

      // single A, held one extra cycle: no double grant
      step("sa0", 0, 1, 1, 4'hA, 0, 0, 0, 1, 0, 4'b0010, 4'hA, 0, 0);
      step("sa1", 0, 1, 1, 4'hA, 0, 0, 0, 0, 0, 4'b0000, 4'hA, 0, 0);
      step("idle1", 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'b0000, 4'hA, 0, 0);

      // contention with prio_b=0, then alternation
      step("ct0", 0, 1, 2, 4'h1, 1, 3, 4'h2, 1, 0, 4'b0100, 4'h1, 0, 1);
      step("ct1", 0, 1, 2, 4'h1, 1, 3, 4'h2, 0, 1, 4'b1000, 4'h2, 0, 1);
      step("ct2", 0, 1, 2, 4'h1, 1, 3, 4'h2, 1, 0, 4'b0100, 4'h1, 0, 1);
      step("ct3", 0, 1, 2, 4'h1, 1, 3, 4'h2, 0, 1, 4'b1000, 4'h2, 0, 1);
      step("idle2", 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'b0000, 4'h2, 0, 1);

      // contention with prio_b=1 favours B
      step("cb0", 0, 1, 1, 4'h7, 1, 2, 4'h8, 0, 1, 4'b0100, 4'h8, 0, 0);
      step("cb1", 0, 1, 1, 4'h7, 1, 2, 4'h8, 1, 0, 4'b0010, 4'h7, 0, 0);
      step("idle3", 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'b0000, 4'h7, 0, 0);

      // uncontended B twice
      step("ub0", 0, 0, 0, 4'h0, 1, 3, 4'h5, 0, 1, 4'b1000, 4'h5, 0, 0);
      step("ub1", 0, 0, 0, 4'h0, 0, 3, 4'h5, 0, 0, 4'b0000, 4'h5, 0, 0);
      step("ub2", 0, 0, 0, 4'h0, 1, 3, 4'h6, 0, 1, 4'b1000, 4'h6, 0, 0);
      step("ub3", 0, 0, 0, 4'h0, 0, 3, 4'h6, 0, 0, 4'b0000, 4'h6, 0, 0);

      // write to register 0
`ifdef RF_WR_PROTECT_EN
      step("z0", 0, 1, 0, 4'hF, 0, 0, 0, 1, 0, 4'b0000, 4'hF, 0, 0);
`else
      step("z0", 0, 1, 0, 4'hF, 0, 0, 0, 1, 0, 4'b0001, 4'hF, 0, 0);
`endif
      step("z1", 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'b0000, 4'hF, 0, 0);

      // reset mid-handshake drops the request, re-arbitrated after
      step("rm0", 1, 1, 1, 4'h9, 0, 0, 0, 0, 0, 4'b0000, 4'h0, 0, 0);
      step("rm1", 0, 1, 1, 4'h9, 0, 0, 0, 1, 0, 4'b0010, 4'h9, 0, 0);
      step("rm2", 0, 0, 1, 4'h9, 0, 0, 0, 0, 0, 4'b0000, 4'h9, 0, 0);

      // NUM_REGS=3: out-of-range then in-range
      req_a2 = 1; addr_a2 = 2'd3; data_a2 = 4'hC;
      @(posedge clk);
      #1;
      chk("oor.ack_a", 32'(ack_a2), 32'd1);
      chk("oor.addr_err", 32'(addr_err2), 32'd1);
      chk("oor.wr_sel", 32'(wr_sel2), 32'd0);
      chk("oor.ack_b", 32'(ack_b2), 32'd0);
      req_a2 = 0;
      @(posedge clk);
      #1;
      chk("oor1.ack_a", 32'(ack_a2), 32'd0);
      chk("oor1.addr_err", 32'(addr_err2), 32'd0);
      req_b2 = 1; addr_b2 = 2'd2; data_b2 = 4'h4;
      @(posedge clk);
      #1;
      chk("inr.ack_b", 32'(ack_b2), 32'd1);
      chk("inr.wr_sel", 32'(wr_sel2), 32'b100);
      chk("inr.addr_err", 32'(addr_err2), 32'd0);
      chk("inr.wr_data", 32'(wr_data2), 32'h4);
      req_b2 = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
